// File: rtl/filter_cfg_arbiter.sv
// rtl/filter_cfg_arbiter.sv - round-robin config-port arbiter with flush sequencer and write spacing
module filter_cfg_arbiter #(
    parameter int KEY_WIDTH  = 32,
    parameter int DATA_WIDTH = 16,
    parameter int TABLES     = 4,
    parameter int TABLE_SIZE = 256,
    parameter int REQUESTERS = 2,
    parameter int MIN_GAP    = 0,
    localparam int TW = $clog2(TABLES),
    localparam int IW = $clog2(TABLE_SIZE)
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [REQUESTERS-1:0]            REQ_VALID,
    output logic [REQUESTERS-1:0]            REQ_READY,
    input  logic [REQUESTERS*KEY_WIDTH-1:0]  REQ_KEY,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [REQUESTERS-1:0]            REQ_EMPTY,
    input  logic [REQUESTERS*TW-1:0]         REQ_TABLE,
    input  logic [REQUESTERS*IW-1:0]         REQ_ITEM,
    input  logic                             FLUSH_START,
    output logic                             FLUSH_BUSY,
    output logic                             FLUSH_DONE,
    output logic [KEY_WIDTH-1:0]             CONFIG_KEY,
    output logic [DATA_WIDTH-1:0]            CONFIG_DATA,
    output logic                             CONFIG_EMPTY,
    output logic [TW-1:0]                    CONFIG_ADDRESS_TABLE,
    output logic [IW-1:0]                    CONFIG_ADDRESS_ITEM,
    output logic                             CONFIG_WRITE
);

    localparam int RW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam int FW = TW + IW;
    localparam logic [RW-1:0] RR_LAST  = RW'(REQUESTERS - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         rr_q, rr_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic                  flast_q, flast_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  empty_q, empty_d;
    logic [TW-1:0]         tbl_q, tbl_d;
    logic [IW-1:0]         item_q, item_d;
    logic                  wr_q, wr_d;

    logic [RW-1:0]         grant_hi, grant_lo, grant;
    logic                  found_hi, found_lo;
    logic                  can_accept;
    logic [KEY_WIDTH-1:0]  sel_key;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_empty;
    logic [TW-1:0]         sel_tbl;
    logic [IW-1:0]         sel_item;

    // Round-robin: lowest valid index at or above rr, else lowest valid index overall.
    always_comb begin
        grant_hi = '0;
        grant_lo = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (REQ_VALID[i]) begin
                grant_lo = RW'(i);
                found_lo = 1'b1;
                if (RW'(i) >= rr_q) begin
                    grant_hi = RW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        grant      = found_hi ? grant_hi : grant_lo;
        can_accept = RESET && (state_q == S_IDLE) && (gap_q == '0) && !FLUSH_START && found_lo;

        REQ_READY = '0;
        sel_key   = '0;
        sel_data  = '0;
        sel_empty = 1'b0;
        sel_tbl   = '0;
        sel_item  = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant == RW'(i)) begin
                REQ_READY[i] = can_accept;
                sel_key      = REQ_KEY[i*KEY_WIDTH +: KEY_WIDTH];
                sel_data     = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_empty    = REQ_EMPTY[i];
                sel_tbl      = REQ_TABLE[i*TW +: TW];
                sel_item     = REQ_ITEM[i*IW +: IW];
            end
        end
    end

    logic          flush_go;
    logic [FW-1:0] fptr;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gap_d    = (gap_q != '0) ? gap_q - GW'(1) : '0;
        fcnt_d   = fcnt_q;
        flast_d  = flast_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        key_d    = key_q;
        data_d   = data_q;
        empty_d  = empty_q;
        tbl_d    = tbl_q;
        item_d   = item_q;
        wr_d     = 1'b0;
        flush_go = 1'b0;
        fptr     = fcnt_q;

        case (state_q)
            S_IDLE: begin
                if (FLUSH_START) begin
                    // The first flush write is launched alongside the state change.
                    state_d  = S_FLUSH;
                    busy_d   = 1'b1;
                    fptr     = '0;
                    fcnt_d   = '0;
                    flast_d  = 1'b0;
                    flush_go = (gap_q == '0);
                end else if (can_accept) begin
                    key_d   = sel_key;
                    data_d  = sel_data;
                    empty_d = sel_empty;
                    tbl_d   = sel_tbl;
                    item_d  = sel_item;
                    wr_d    = 1'b1;
                    gap_d   = GAP_LOAD;
                    rr_d    = (grant == RR_LAST) ? '0 : grant + RW'(1);
                end
            end
            S_FLUSH: begin
                if (flast_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    flast_d = 1'b0;
                    fcnt_d  = '0;
                end else begin
                    flush_go = (gap_q == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_go) begin
            key_d   = '0;
            data_d  = '0;
            empty_d = 1'b1;
            {tbl_d, item_d} = fptr;
            wr_d    = 1'b1;
            gap_d   = GAP_LOAD;
            fcnt_d  = fptr + FW'(1);
            flast_d = &fptr;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            gap_q   <= '0;
            fcnt_q  <= '0;
            flast_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            key_q   <= '0;
            data_q  <= '0;
            empty_q <= 1'b0;
            tbl_q   <= '0;
            item_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            fcnt_q  <= fcnt_d;
            flast_q <= flast_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            key_q   <= key_d;
            data_q  <= data_d;
            empty_q <= empty_d;
            tbl_q   <= tbl_d;
            item_q  <= item_d;
            wr_q    <= wr_d;
        end
    end

    assign FLUSH_BUSY           = busy_q;
    assign FLUSH_DONE           = done_q;
    assign CONFIG_KEY           = key_q;
    assign CONFIG_DATA          = data_q;
    assign CONFIG_EMPTY         = empty_q;
    assign CONFIG_ADDRESS_TABLE = tbl_q;
    assign CONFIG_ADDRESS_ITEM  = item_q;
    assign CONFIG_WRITE         = wr_q;

endmodule

// File: tb/tb_filter_cfg_arbiter.sv
// tb/tb_filter_cfg_arbiter.sv - directed bench for filter_cfg_arbiter
module tb_filter_cfg_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  req_valid;
    logic [63:0] req_key;
    logic [31:0] req_data;
    logic [1:0]  req_empty;
    logic [3:0]  req_table;
    logic [5:0]  req_item;
    logic        flush_start;

    logic [1:0]  ready_a, ready_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [31:0] key_a, key_b;
    logic [15:0] data_a, data_b;
    logic        empty_a, empty_b, wr_a, wr_b;
    logic [1:0]  tbl_a, tbl_b;
    logic [2:0]  item_a, item_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    filter_cfg_arbiter #(
        .KEY_WIDTH(32), .DATA_WIDTH(16), .TABLES(4), .TABLE_SIZE(8),
        .REQUESTERS(2), .MIN_GAP(0)
    ) u_dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(req_valid), .REQ_READY(ready_a),
        .REQ_KEY(req_key), .REQ_DATA(req_data), .REQ_EMPTY(req_empty),
        .REQ_TABLE(req_table), .REQ_ITEM(req_item),
        .FLUSH_START(flush_start), .FLUSH_BUSY(busy_a), .FLUSH_DONE(done_a),
        .CONFIG_KEY(key_a), .CONFIG_DATA(data_a), .CONFIG_EMPTY(empty_a),
        .CONFIG_ADDRESS_TABLE(tbl_a), .CONFIG_ADDRESS_ITEM(item_a),
        .CONFIG_WRITE(wr_a)
    );

    filter_cfg_arbiter #(
        .KEY_WIDTH(32), .DATA_WIDTH(16), .TABLES(4), .TABLE_SIZE(8),
        .REQUESTERS(2), .MIN_GAP(3)
    ) u_gap (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(req_valid), .REQ_READY(ready_b),
        .REQ_KEY(req_key), .REQ_DATA(req_data), .REQ_EMPTY(req_empty),
        .REQ_TABLE(req_table), .REQ_ITEM(req_item),
        .FLUSH_START(flush_start), .FLUSH_BUSY(busy_b), .FLUSH_DONE(done_b),
        .CONFIG_KEY(key_b), .CONFIG_DATA(data_b), .CONFIG_EMPTY(empty_b),
        .CONFIG_ADDRESS_TABLE(tbl_b), .CONFIG_ADDRESS_ITEM(item_b),
        .CONFIG_WRITE(wr_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_req(input int r, input logic [31:0] k, input logic [15:0] d,
                           input logic e, input logic [1:0] t, input logic [2:0] it);
        req_key[r*32 +: 32] = k;
        req_data[r*16 +: 16] = d;
        req_empty[r]         = e;
        req_table[r*2 +: 2]  = t;
        req_item[r*3 +: 3]   = it;
    endtask

    task automatic apply_reset();
        req_valid   = 2'b00;
        flush_start = 1'b0;
        RESET       = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        #1;
        chk({tag, "_write"}, wr_a, 0);
        chk({tag, "_key"}, key_a, 0);
        chk({tag, "_data"}, data_a, 0);
        chk({tag, "_empty"}, empty_a, 0);
        chk({tag, "_addr"}, {tbl_a, item_a}, 0);
        chk({tag, "_ready"}, ready_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic saw_done;
        logic saw_write;
        req_key  = '0;
        req_data = '0;
        req_empty = '0;
        req_table = '0;
        req_item  = '0;

        apply_reset();
        chk_all_zero("reset");
        tick();

        // Single request from requester 0.
        set_req(0, 32'hDEADBEEF, 16'h1234, 1'b0, 2'd2, 3'd5);
        req_valid = 2'b01;
        #1 chk("single_ready", ready_a, 2'b01);
        tick();
        req_valid = 2'b00;
        #1;
        chk("single_write", wr_a, 1);
        chk("single_key", key_a, 32'hDEADBEEF);
        chk("single_data", data_a, 16'h1234);
        chk("single_empty", empty_a, 0);
        chk("single_addr", {tbl_a, item_a}, {2'd2, 3'd5});
        tick();
        #1;
        chk("single_one_pulse", wr_a, 0);
        chk("single_hold_key", key_a, 32'hDEADBEEF);

        // Round-robin with both requesters continuously valid.
        apply_reset();
        set_req(0, 32'h000000A0, 16'h00A0, 1'b0, 2'd0, 3'd1);
        set_req(1, 32'h000000B1, 16'h00B1, 1'b1, 2'd3, 3'd6);
        req_valid = 2'b11;
        for (int n = 0; n < 6; n++) begin
            #1 chk($sformatf("rr_ready%0d", n), ready_a, (n % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            if (n == 5) req_valid = 2'b00;
            #1;
            chk($sformatf("rr_write%0d", n), wr_a, 1);
            chk($sformatf("rr_key%0d", n), key_a, (n % 2 == 0) ? 32'hA0 : 32'hB1);
        end

        // Gap enforcement on the MIN_GAP=3 instance.
        apply_reset();
        set_req(1, 32'h0BADF00D, 16'h7777, 1'b0, 2'd1, 3'd3);
        for (int c = 0; c < 17; c++) begin
            req_valid = (c <= 12) ? 2'b10 : 2'b00;
            #1;
            chk($sformatf("gap_ready%0d", c), ready_b,
                ((c % 4 == 0) && (c <= 12)) ? 2'b10 : 2'b00);
            chk($sformatf("gap_write%0d", c), wr_b,
                ((c >= 1) && ((c - 1) % 4 == 0) && (c <= 13)) ? 1 : 0);
            tick();
        end

        // Flush colliding with a request on requester 0; mid-flush FLUSH_START ignored.
        apply_reset();
        set_req(0, 32'hCAFE0001, 16'h5A5A, 1'b0, 2'd3, 3'd7);
        req_valid   = 2'b01;
        flush_start = 1'b1;
        #1 chk("coll_ready", ready_a, 2'b00);
        tick();
        for (int n = 0; n < 32; n++) begin
            flush_start = (n == 5);
            #1;
            chk($sformatf("fl_busy%0d", n), busy_a, 1);
            chk($sformatf("fl_write%0d", n), wr_a, 1);
            chk($sformatf("fl_entry%0d", n), {empty_a, key_a, data_a}, {1'b1, 48'h0});
            chk($sformatf("fl_addr%0d", n), {tbl_a, item_a}, n);
            chk($sformatf("fl_stall%0d", n), {ready_a, done_a}, 0);
            tick();
        end
        flush_start = 1'b0;
        #1;
        chk("fl_done", done_a, 1);
        chk("fl_busy_end", busy_a, 0);
        chk("fl_write_end", wr_a, 0);
        chk("coll_ready_back", ready_a, 2'b01);
        tick();
        req_valid = 2'b00;
        #1;
        chk("coll_write", wr_a, 1);
        chk("coll_key", key_a, 32'hCAFE0001);
        chk("coll_addr", {empty_a, tbl_a, item_a}, {1'b0, 2'd3, 3'd7});
        chk("fl_done_once", done_a, 0);

        // Reset after the 10th flush write, then a fresh flush restarts at (0,0).
        tick();
        flush_start = 1'b1;
        tick();
        flush_start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            #1 chk($sformatf("rst_fl_addr%0d", n), {wr_a, tbl_a, item_a}, {1'b1, 5'(n)});
            if (n == 9) RESET = 1'b0;
            tick();
        end
        RESET = 1'b1;
        chk_all_zero("midrst");
        saw_done  = 1'b0;
        saw_write = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            #1;
            saw_done  = saw_done | done_a;
            saw_write = saw_write | wr_a;
        end
        chk("midrst_no_done", saw_done, 0);
        chk("midrst_no_write", saw_write, 0);
        flush_start = 1'b1;
        tick();
        flush_start = 1'b0;
        #1;
        chk("restart_busy", busy_a, 1);
        chk("restart_first", {wr_a, empty_a, tbl_a, item_a}, {1'b1, 1'b1, 5'd0});
        tick();
        #1 chk("restart_second", {wr_a, tbl_a, item_a}, {1'b1, 5'd1});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_cfg_arbiter.md
# filter_cfg_arbiter

Configuration-port controller for the `filter` lookup block. Shares the filter's single table-write port between `REQUESTERS` independent clients using round-robin arbitration with a valid/ready handshake. Sequences a hardware flush that writes an empty entry to every item of every table. Enforces a programmable minimum spacing between writes. It sits directly in front of the filter's `CONFIG_*` inputs and drives them from registers.

## Interface
- `KEY_WIDTH`, 32, key width; must equal the filter's `KEY_WIDTH`.
- `DATA_WIDTH`, 16, data width; must equal the filter's `DATA_WIDTH`.
- `TABLES`, 4, number of tables; power of two, ≥2. TW = clog2(TABLES).
- `TABLE_SIZE`, 256, items per table; power of two, ≥2. IW = clog2(TABLE_SIZE).
- `REQUESTERS`, 2, number of write clients, ≥1.
- `MIN_GAP`, 0, minimum idle cycles between consecutive `CONFIG_WRITE` pulses.

Ports:
- `CLK`  in  1  single clock; all logic is on the rising edge.
- `RESET`  in  1  synchronous, active-low reset.
- `REQ_VALID`  in  REQUESTERS  per-requester request valid.
- `REQ_READY`  out  REQUESTERS  per-requester accept; at most one bit set.
- `REQ_KEY`  in  REQUESTERS*KEY_WIDTH  keys; requester i occupies slice [i*KEY_WIDTH +: KEY_WIDTH].
- `REQ_DATA`  in  REQUESTERS*DATA_WIDTH  data, sliced the same way.
- `REQ_EMPTY`  in  REQUESTERS  set to 1 to invalidate the entry (delete).
- `REQ_TABLE`  in  REQUESTERS*TW  target table.
- `REQ_ITEM`  in  REQUESTERS*IW  target item.
- `FLUSH_START`  in  1  request a full-table flush.
- `FLUSH_BUSY`  out  1  flush in progress.
- `FLUSH_DONE`  out  1  one-cycle pulse when the flush completes.
- `CONFIG_KEY`, `CONFIG_DATA`, `CONFIG_EMPTY`, `CONFIG_ADDRESS_TABLE`, `CONFIG_ADDRESS_ITEM`, `CONFIG_WRITE`  out  KEY_WIDTH / DATA_WIDTH / 1 / TW / IW / 1  registered write to the filter.

## Operation
- States:
  - IDLE: serve requests.
  - FLUSH: walk all entries.
- Gap counter `gap`:
  - Loaded with MIN_GAP on every cycle `CONFIG_WRITE` is asserted.
  - Otherwise decrements toward 0.
  - A new write may be launched only when `gap`=0.
- IDLE arbitration:
  - Round-robin pointer `rr`, 0..REQUESTERS-1.
  - Grant goes to the first requester with `REQ_VALID`=1, searching from index `rr` upward with wrap-around.
- `REQ_READY[g]`=1 only when all of these hold:
  - state IDLE
  - `gap`=0
  - `FLUSH_START`=0
  - g is the granted requester
- `REQ_READY` depends combinationally on `REQ_VALID`. Requesters must not make `REQ_VALID` depend on `REQ_READY`.
- Once raised, `REQ_VALID` and its fields must hold until accepted.
- On accept of requester g:
  - Its fields are registered onto `CONFIG_*` and `CONFIG_WRITE`=1 in the next cycle.
  - `rr` ← (g+1) mod REQUESTERS.
- IDLE → FLUSH: `FLUSH_START`=1 while in IDLE.
  - Flush wins over any same-cycle request; no request is accepted that cycle.
- FLUSH sequencing:
  - Counters (t, i) start at (0, 0).
  - In each FLUSH cycle with `gap`=0, issue one write: key=0, data=0, `CONFIG_EMPTY`=1, table=t, item=i.
  - Then increment i; when i wraps from TABLE_SIZE-1 to 0, increment t.
  - Total writes: TABLES*TABLE_SIZE.
- FLUSH → IDLE:
  - Taken the cycle after the write to (TABLES-1, TABLE_SIZE-1).
  - `FLUSH_DONE`=1 and `FLUSH_BUSY`=0 in that same cycle.
- `FLUSH_START` during FLUSH is ignored; no restart, no queueing.
- `rr` is unchanged by a flush.

## Timing
- Reset:
  - Applied while `RESET`=0 at a rising edge.
  - All outputs read 0 on the following cycle: `CONFIG_*`, `CONFIG_WRITE`, `REQ_READY`, `FLUSH_BUSY`, `FLUSH_DONE`.
  - Internal state after reset: state IDLE, `rr`=0, `gap`=0, flush counters 0.
- Reset mid-flush aborts the flush; no `FLUSH_DONE` is produced.
- Request latency: accept at edge k → `CONFIG_WRITE` high during cycle k+1, for exactly one cycle per accept.
- Throughput:
  - One write per MIN_GAP+1 cycles.
  - With MIN_GAP=0, back-to-back writes every cycle are allowed.
- `CONFIG_*` fields hold their last written value while `CONFIG_WRITE`=0.
- Flush timing:
  - `FLUSH_START` sampled at edge k → `FLUSH_BUSY`=1 from cycle k+1.
  - First flush write in cycle k+1 if `gap`=0 then; otherwise delayed until `gap` reaches 0.
  - With MIN_GAP=0, the flush occupies TABLES*TABLE_SIZE cycles and `FLUSH_DONE` falls at cycle k+TABLES*TABLE_SIZE+1.

## Test plan
- Single request: TABLES=4, TABLE_SIZE=8, MIN_GAP=0; requester 0 sends key=0xDEADBEEF, data=0x1234, empty=0, table=2, item=5 → exactly one `CONFIG_WRITE`, one cycle after accept, with those exact fields.
- Round-robin: both requesters hold `REQ_VALID` continuously for 6 transactions → grants alternate 0,1,0,1,0,1 and writes occur every cycle.
- Gap enforcement: MIN_GAP=3, requester 1 issues 4 back-to-back requests → `CONFIG_WRITE` pulses are exactly 4 cycles apart and `REQ_READY` is low in between.
- Flush:
  - Stimulus: TABLES=4, TABLE_SIZE=8, MIN_GAP=0; pulse `FLUSH_START`.
  - 32 consecutive writes, all with `CONFIG_EMPTY`=1, address order (0,0)…(0,7),(1,0)…(3,7).
  - `FLUSH_BUSY` high for 32 cycles; one-cycle `FLUSH_DONE` immediately after; requests stalled throughout.
- Collision and reset:
  - `FLUSH_START` coincides with `REQ_VALID[0]` → request is not accepted; the flush runs; the request is accepted first cycle back in IDLE.
  - `RESET`=0 asserted after the 10th flush write → next cycle all outputs are 0, no `FLUSH_DONE` occurs, and a following `FLUSH_START` restarts at (0,0).
